// File: rtl/div_ctrl_pkg.sv
// Shared state codes and default sizing for the EX-stage divider sequencer.
package div_ctrl_pkg;

    localparam int DIV_DATA_W  = 32;
    localparam int DIV_TIMEOUT = 40;  // must exceed the divider's worst-case latency
    localparam int DIV_CNT_W   = 6;   // 2**DIV_CNT_W > DIV_TIMEOUT

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: latches DIV/DIVU operands, runs the start/cancel handshake
// with the iterative divider, stalls EX while it works, and retires the
// {remainder, quotient} pair as a single-cycle HILO write. Covers flush,
// divide-by-zero and a watchdog abort.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W  = DIV_DATA_W,
    parameter int TIMEOUT = DIV_TIMEOUT,
    parameter int CNT_W   = DIV_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flushE,
    input  logic                div_req,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                div_ready,
    input  logic [2*DATA_W-1:0] div_result,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_opa,
    output logic [DATA_W-1:0]   div_opb,
    output logic                div_cancel,
    output logic                div_stall,
    output logic                hilo_we,
    output logic [2*DATA_W-1:0] hilo_wdata,
    output logic                div_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    div_state_e          state_q, state_d;
    logic                sgn_q, sgn_d;
    logic [DATA_W-1:0]   opa_d, opb_d;
    logic [2*DATA_W-1:0] wdata_d;
    logic [CNT_W-1:0]    cnt_q;

    // Next-state, operand capture, result capture and the single-cycle strobes.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        sgn_d      = sgn_q;
        opa_d      = div_opa;
        opb_d      = div_opb;
        wdata_d    = hilo_wdata;
        div_cancel = 1'b0;
        div_err    = 1'b0;
        hilo_we    = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (div_req && !flushE) begin
                    opa_d = a;
                    opb_d = b;
                    sgn_d = signed_i;
                    if (b != '0) begin
                        state_d = DIV_BUSY;
                    end else begin
                        // Divide-by-zero bypasses the divider: hi=dividend, lo=all ones.
                        state_d = DIV_DONE;
                        wdata_d = {a, {DATA_W{1'b1}}};
                    end
                end
            end
            DIV_BUSY: begin
                if (flushE) begin
                    div_cancel = 1'b1;
                    state_d    = DIV_IDLE;
                end else if (div_ready) begin
                    wdata_d = div_result;
                    state_d = DIV_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    div_cancel = 1'b1;
                    div_err    = 1'b1;
                    state_d    = DIV_IDLE;
                end
            end
            DIV_DONE: begin
                // div_req is ignored here so the retiring instruction cannot re-issue.
                hilo_we = !flushE;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Stall covers the accepting IDLE cycle and all of BUSY; held low while in reset.
    assign div_stall = rst && (((state_q == DIV_IDLE) && div_req && !flushE) ||
                               (state_q == DIV_BUSY));

    // State, latched operands, result register and the registered divider controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_IDLE;
            sgn_q      <= 1'b0;
            div_opa    <= '0;
            div_opb    <= '0;
            hilo_wdata <= '0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            sgn_q      <= sgn_d;
            div_opa    <= opa_d;
            div_opb    <= opb_d;
            hilo_wdata <= wdata_d;
            div_start  <= (state_d == DIV_BUSY);
            div_signed <= (state_d == DIV_BUSY) && sgn_d;
        end
    end

    // Watchdog: zero outside BUSY, so it restarts from zero on every BUSY entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == DIV_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural divider answers the start
// handshake after a chosen latency; expected HILO values go into a queue and
// a negedge monitor pops and compares them whenever hilo_we is seen.
module tb_div_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushE;
    logic        div_req;
    logic        signed_i;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_cancel;
    logic        div_stall;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        div_err;

    int          n_tests      = 0;
    int          n_fail       = 0;
    int          we_count     = 0;
    int          start_count  = 0;
    int          cancel_count = 0;
    int          err_count    = 0;
    logic        prev_we      = 1'b0;
    logic        cur_signed   = 1'b0;
    int          div_lat      = 0;
    bit          div_stuck    = 1'b0;
    int          dcnt         = 0;
    logic [31:0] last_opa     = '0;
    logic [63:0] exp_q[$];

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flushE     (flushE),
        .div_req    (div_req),
        .signed_i   (signed_i),
        .a          (a),
        .b          (b),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .div_cancel (div_cancel),
        .div_stall  (div_stall),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .div_err    (div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics: quotient truncates toward zero, remainder takes
    // the dividend's sign; divide-by-zero yields {dividend, all ones}.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural divider: ready once start has been high for more than div_lat cycles.
    initial begin
        div_ready  = 1'b0;
        div_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!div_start) begin
                dcnt       = 0;
                div_ready  = 1'b0;
                div_result = '0;
            end else begin
                dcnt++;
                if (!div_stuck && dcnt > div_lat) begin
                    div_ready  = 1'b1;
                    div_result = ref_div(div_opa, div_opb, div_signed);
                end
            end
        end
    end

    // Monitor: scoreboard pop on hilo_we, event counters, div_signed during BUSY.
    always @(negedge clk) begin
        if (hilo_we) begin
            we_count++;
            check("hilo_we_single", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL hilo_unexpected: got write %h expected none", hilo_wdata);
            end else begin
                check("hilo_wdata", hilo_wdata, exp_q.pop_front());
            end
        end
        if (div_start) begin
            start_count++;
            check("div_signed_busy", {63'd0, div_signed}, {63'd0, cur_signed});
        end
        if (div_cancel) cancel_count++;
        if (div_err) err_count++;
        prev_we = hilo_we;
    end

    // One full DIV/DIVU; operands are scrambled while busy to prove they are held.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic ts, input int n);
        int stall_cnt, guard, we0, st0, ca0;
        exp_q.push_back(ref_div(ta, tb_v, ts));
        div_lat    = n;
        cur_signed = ts;
        we0        = we_count;
        st0        = start_count;
        ca0        = cancel_count;
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        a        = ta;
        b        = tb_v;
        signed_i = ts;
        last_opa = ta;
        stall_cnt = 0;
        guard     = 0;
        forever begin
            @(negedge clk);
            if (!div_stall) break;
            stall_cnt++;
            guard++;
            if (guard > 200) begin
                check("stall_bound", 64'(guard), 64'd200);
                break;
            end
            @(posedge clk);
            #1;
            a        = $urandom;
            b        = $urandom;
            signed_i = 1'($urandom_range(0, 1));
        end
        check("stall_cycles", 64'(stall_cnt), (tb_v == 0) ? 64'd1 : 64'(n + 2));
        @(posedge clk);
        #1;
        div_req = 1'b0;
        check("we_pulses", 64'(we_count - we0), 64'd1);
        check("start_cycles", 64'(start_count - st0), (tb_v == 0) ? 64'd0 : 64'(n + 1));
        check("no_cancel", 64'(cancel_count - ca0), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_idle_flush();
        @(posedge clk);
        #1;
        div_req = 1'b1;
        flushE  = 1'b1;
        a       = ~last_opa;
        b       = 32'd3;
        @(negedge clk);
        check("idle_flush_stall", {63'd0, div_stall}, 64'd0);
        @(posedge clk);
        #1;
        div_req = 1'b0;
        flushE  = 1'b0;
        @(negedge clk);
        check("idle_flush_start", {63'd0, div_start}, 64'd0);
        check("idle_flush_opa", {32'd0, div_opa}, {32'd0, last_opa});
    endtask

    task automatic run_flush_busy();
        int we0, ca0, er0;
        div_lat    = 20;
        cur_signed = 1'b1;
        we0 = we_count;
        ca0 = cancel_count;
        er0 = err_count;
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        signed_i = 1'b1;
        a        = 32'd1000;
        b        = 32'd7;
        last_opa = 32'd1000;
        repeat (3) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        check("flush_cancel", {63'd0, div_cancel}, 64'd1);
        @(posedge clk);
        #1;
        flushE  = 1'b0;
        div_req = 1'b0;
        @(negedge clk);
        check("flush_idle_start", {63'd0, div_start}, 64'd0);
        check("flush_idle_stall", {63'd0, div_stall}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_write", 64'(we_count - we0), 64'd0);
        check("flush_cancel_count", 64'(cancel_count - ca0), 64'd1);
        check("flush_no_err", 64'(err_count - er0), 64'd0);
    endtask

    task automatic run_flush_done();
        int we0;
        div_lat    = 2;
        cur_signed = 1'b0;
        we0 = we_count;
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        signed_i = 1'b0;
        a        = 32'd77;
        b        = 32'd5;
        last_opa = 32'd77;
        repeat (4) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        check("flushdone_stall", {63'd0, div_stall}, 64'd0);
        check("flushdone_we", {63'd0, hilo_we}, 64'd0);
        @(posedge clk);
        #1;
        flushE  = 1'b0;
        div_req = 1'b0;
        @(posedge clk);
        #1;
        check("flushdone_no_write", 64'(we_count - we0), 64'd0);
    endtask

    task automatic run_timeout();
        int busy, found, er0;
        div_stuck  = 1'b1;
        cur_signed = 1'b0;
        er0 = err_count;
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        signed_i = 1'b0;
        a        = 32'd99;
        b        = 32'd4;
        last_opa = 32'd99;
        busy  = 0;
        found = 0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge clk);
            if (div_start) busy++;
            if (div_err) begin
                found = 1;
                break;
            end
        end
        check("timeout_seen", 64'(found), 64'd1);
        check("timeout_cycle", 64'(busy), 64'(TIMEOUT));
        check("timeout_cancel", {63'd0, div_cancel}, 64'd1);
        @(posedge clk);
        #1;
        div_req   = 1'b0;
        div_stuck = 1'b0;
        @(negedge clk);
        check("timeout_idle_start", {63'd0, div_start}, 64'd0);
        check("timeout_idle_stall", {63'd0, div_stall}, 64'd0);
        check("timeout_err_count", 64'(err_count - er0), 64'd1);
    endtask

    task automatic run_reset_mid_busy();
        div_lat    = 20;
        cur_signed = 1'b1;
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        signed_i = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'd9;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_start", {63'd0, div_start}, 64'd1);
        rst = 1'b0;
        #1;
        check("rst_start", {63'd0, div_start}, 64'd0);
        check("rst_signed", {63'd0, div_signed}, 64'd0);
        check("rst_opa", {32'd0, div_opa}, 64'd0);
        check("rst_opb", {32'd0, div_opb}, 64'd0);
        check("rst_stall", {63'd0, div_stall}, 64'd0);
        check("rst_wdata", hilo_wdata, 64'd0);
        check("rst_strobes", {61'd0, div_cancel, hilo_we, div_err}, 64'd0);
        div_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        last_opa = '0;
    endtask

    task automatic run_random(input int count);
        logic [31:0] ra, rb;
        for (int i = 0; i < count; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 16);
                2:       rb = -($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd3;
            run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst      = 1'b0;
        flushE   = 1'b0;
        div_req  = 1'b0;
        signed_i = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check("reset_start", {63'd0, div_start}, 64'd0);
        check("reset_stall", {63'd0, div_stall}, 64'd0);
        check("reset_wdata", hilo_wdata, 64'd0);
        check("reset_opab", {div_opa, div_opb}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b1, 3);
        run_div(-32'sd7, 32'd2, 1'b1, 2);
        run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 4);
        run_div(32'd5, 32'd0, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_idle_flush();
        run_flush_busy();
        run_flush_done();
        run_timeout();
        run_reset_mid_busy();
        run_div(32'd4321, 32'd10, 1'b0, 1);
        run_random(25);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
